// File: rtl/vga_scanout.sv
// VGA raster generator with frame-buffer read issue and latency-matched pin outputs.
// Define VGA_SCANOUT_TEST_PATTERN_EN to replace i_color with eight vertical colour bars.
module vga_scanout #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_POL    = 1'b0,
    parameter int CLK_DIV     = 4,
    parameter int SCALE_SHIFT = 1,
    parameter int RD_LATENCY  = 2,
    parameter int COORD_W     = 10
) (
    input  logic               clk,
    input  logic               reset,
    output logic [COORD_W-1:0] ox,
    output logic [COORD_W-1:0] oy,
    output logic               rd_valid,
    input  logic [23:0]        i_color,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b,
    output logic               frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    localparam int PW = 6;
    localparam logic [HW-1:0] BAR_LAST = HW'(H_ACTIVE / 8 - 1);
`else
    localparam int PW = 3;
`endif

    logic [DW-1:0] div_cnt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          tick;
    logic          active;
    logic          hs_raw;
    logic          vs_raw;
    logic [PW-1:0] raw;
    logic [PW-1:0] pipe [RD_LATENCY];
    logic [PW-1:0] tail;

    assign tick   = (div_cnt == DIV_LAST);
    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_raw = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs_raw = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign tail   = pipe[RD_LATENCY-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    // frame_start is the one output that is a single clk wide, not a tick wide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ox          <= '0;
            oy          <= '0;
            rd_valid    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
            if (tick) begin
                rd_valid <= active;
                ox       <= active ? COORD_W'(h_cnt >> SCALE_SHIFT) : '0;
                oy       <= active ? COORD_W'(v_cnt >> SCALE_SHIFT) : '0;
            end
        end
    end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic [HW-1:0] bar_px;
    logic [2:0]    bar_idx;
    logic [2:0]    bar;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (tick) begin
            if (h_cnt == H_LAST) begin
                bar_px  <= '0;
                bar_idx <= '0;
            end else if (bar_px == BAR_LAST) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 1'b1;
            end else begin
                bar_px <= bar_px + 1'b1;
            end
        end
    end

    assign raw = {bar_idx, hs_raw, vs_raw, active};
    assign bar = tail[5:3];
`else
    assign raw = {hs_raw, vs_raw, active};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= '0;
        end else if (tick) begin
            pipe[0] <= raw;
            for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            de    <= 1'b0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else if (tick) begin
            de    <= tail[0];
            hsync <= SYNC_POL ? tail[2] : ~tail[2];
            vsync <= SYNC_POL ? tail[1] : ~tail[1];
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
            // bar index bits map straight onto the inverted colour channels
            vga_r <= tail[0] ? {8{~bar[1]}} : '0;
            vga_g <= tail[0] ? {8{~bar[2]}} : '0;
            vga_b <= tail[0] ? {8{~bar[0]}} : '0;
`else
            {vga_r, vga_g, vga_b} <= tail[0] ? i_color : 24'h0;
`endif
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: default-timing instance plus a tiny-raster instance
// (CLK_DIV=1, positive syncs) for frame wrap and mid-frame reset.
module tb_vga_scanout;

    typedef struct packed {
        logic [9:0]  ox;
        logic [9:0]  oy;
        logic        rv;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [23:0] rgb;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b0;
    logic [9:0]  ox_a, oy_a;
    logic        rv_a, hs_a, vs_a, de_a, fs_a;
    logic [7:0]  r_a, g_a, b_a;
    logic [23:0] icol_a = '0;

    logic        rst_b = 1'b0;
    logic [3:0]  ox_b, oy_b;
    logic        rv_b, hs_b, vs_b, de_b, fs_b;
    logic [7:0]  r_b, g_b, b_b;
    logic [23:0] icol_b = '0;

    int errors = 0;
    int checks = 0;
    int shown = 0;
    int n_a = 0;
    int n_b = 0;

    vga_scanout u_a (
        .clk(clk), .reset(rst_a), .ox(ox_a), .oy(oy_a), .rd_valid(rv_a),
        .i_color(icol_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .frame_start(fs_a)
    );

    vga_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .CLK_DIV(1), .SCALE_SHIFT(1),
        .RD_LATENCY(3), .COORD_W(4)
    ) u_b (
        .clk(clk), .reset(rst_b), .ox(ox_b), .oy(oy_b), .rd_valid(rv_b),
        .i_color(icol_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .frame_start(fs_b)
    );

    // Outputs after n clk edges since reset release, from tick index arithmetic.
    function automatic obs_t model(input int n, input int ha, input int hf,
                                   input int hsw, input int hb, input int va,
                                   input int vf, input int vsw, input int vb,
                                   input int pol, input int dv, input int sh,
                                   input int lat, input int cw);
        obs_t e;
        int ht, vt, k, h, v, q, mask;
        logic [9:0] x, y;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        mask = (1 << cw) - 1;
        e = '0;
        e.hs = (pol == 0);
        e.vs = (pol == 0);
        if (n < dv) return e;
        k = n / dv - 1;
        h = k % ht;
        v = (k / ht) % vt;
        if (h < ha && v < va) begin
            e.rv = 1'b1;
            e.ox = 10'((h >> sh) & mask);
            e.oy = 10'((v >> sh) & mask);
        end
        e.fs = (n % dv == 0) && (k % (ht * vt) == 0);
        q = k - lat;
        if (q >= 0) begin
            h = q % ht;
            v = (q / ht) % vt;
            if (h < ha && v < va) begin
                e.de = 1'b1;
                x = 10'((h >> sh) & mask);
                y = 10'((v >> sh) & mask);
                e.rgb = {x[7:0], y[7:0], 8'hA5};
            end
            if (h >= ha + hf && h < ha + hf + hsw) e.hs = (pol != 0);
            if (v >= va + vf && v < va + vf + vsw) e.vs = (pol != 0);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    always @(posedge clk or posedge rst_a)
        if (rst_a) n_a = 0;
        else n_a = n_a + 1;

    always @(posedge clk or posedge rst_b)
        if (rst_b) n_b = 0;
        else n_b = n_b + 1;

    // Frame buffer stand-in: colour returns L*DIV-1 clk after the address.
    initial begin
        logic [23:0] ha [8];
        logic [23:0] hb [3];
        for (int j = 0; j < 8; j++) ha[j] = '0;
        for (int j = 0; j < 3; j++) hb[j] = '0;
        forever begin
            @(negedge clk);
            for (int j = 7; j > 0; j--) ha[j] = ha[j-1];
            ha[0] = {ox_a[7:0], oy_a[7:0], 8'hA5};
            icol_a = ha[7];
            for (int j = 2; j > 0; j--) hb[j] = hb[j-1];
            hb[0] = {4'h0, ox_b, 4'h0, oy_b, 8'hA5};
            icol_b = hb[2];
        end
    end

    always @(negedge clk) begin
        obs_t ea, ga, eb, gb;
        ea = model(n_a, 640, 16, 96, 48, 480, 10, 2, 33, 0, 4, 1, 2, 10);
        ga = {ox_a, oy_a, rv_a, hs_a, vs_a, de_a, fs_a, r_a, g_a, b_a};
        eb = model(n_b, 16, 2, 3, 3, 6, 1, 2, 2, 1, 1, 1, 3, 4);
        gb = {6'h0, ox_b, 6'h0, oy_b, rv_b, hs_b, vs_b, de_b, fs_b, r_b, g_b, b_b};
        checks += 2;
        if (ga !== ea) begin
            errors++;
            if (shown < 20) $display("FAIL cycle_a n=%0d got=%h want=%h", n_a, ga, ea);
            shown++;
        end
        if (gb !== eb) begin
            errors++;
            if (shown < 20) $display("FAIL cycle_b n=%0d got=%h want=%h", n_b, gb, eb);
            shown++;
        end
    end

    int hs_fall [2] = '{-1, -1};
    int hs_nf = 0;
    int hs_rise = -1;
    int de_rise = -1;
    int de_fall = -1;
    int fs_cnt_b = 0;
    int fs_prev_b = -1;
    int fs_last_b = -1;

    initial begin
        logic phs, pde;
        phs = 1'b1;
        pde = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_a) begin
                if (phs && !hs_a && hs_nf < 2) begin
                    hs_fall[hs_nf] = n_a;
                    hs_nf++;
                end
                if (!phs && hs_a && hs_rise < 0) hs_rise = n_a;
                if (!pde && de_a && de_rise < 0) de_rise = n_a;
                if (pde && !de_a && de_fall < 0) de_fall = n_a;
            end
            if (fs_b) begin
                fs_cnt_b++;
                fs_prev_b = fs_last_b;
                fs_last_b = n_b;
            end
            phs = hs_a;
            pde = de_a;
        end
    end

    task automatic goto_a(input int t);
        int g;
        g = 0;
        while (n_a < t && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("goto_a", 64'(n_a), 64'(t));
    endtask

    task automatic goto_b(input int t);
        int g;
        g = 0;
        while (n_b < t && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("goto_b", 64'(n_b), 64'(t));
    endtask

    task automatic run_a();
        #1 rst_a = 1'b1;
        repeat (5) @(negedge clk);
        chk("a_rst_hsync", 64'(hs_a), 64'd1);
        chk("a_rst_vsync", 64'(vs_a), 64'd1);
        chk("a_rst_de", 64'(de_a), 64'd0);
        chk("a_rst_rgb", 64'({r_a, g_a, b_a}), 64'd0);
        chk("a_rst_ox", 64'({ox_a, oy_a}), 64'd0);
        #2 rst_a = 1'b0;
        goto_a(3);
        chk("a_fs_clk3", 64'(fs_a), 64'd0);
        chk("a_rv_clk3", 64'(rv_a), 64'd0);
        goto_a(4);
        chk("a_fs_clk4", 64'(fs_a), 64'd1);
        chk("a_xy_clk4", 64'({ox_a, oy_a}), 64'd0);
        chk("a_rv_clk4", 64'(rv_a), 64'd1);
        goto_a(5);
        chk("a_fs_clk5", 64'(fs_a), 64'd0);
        goto_a(12);
        chk("a_ox_h2", 64'(ox_a), 64'd1);
        chk("a_rgb_p0", 64'({r_a, g_a, b_a}), 64'h0000A5);
        chk("a_de_p0", 64'(de_a), 64'd1);
        goto_a(16);
        chk("a_ox_h3", 64'(ox_a), 64'd1);
        goto_a(20);
        chk("a_rgb_p2", 64'({r_a, g_a, b_a}), 64'h0100A5);
        goto_a(2560);
        chk("a_ox_h639", 64'(ox_a), 64'd319);
        chk("a_rv_h639", 64'(rv_a), 64'd1);
        goto_a(2564);
        chk("a_rv_h640", 64'(rv_a), 64'd0);
        chk("a_ox_h640", 64'(ox_a), 64'd0);
        goto_a(6000);
        chk("a_hs_fall1", 64'(hs_fall[0]), 64'd2636);
        chk("a_hs_period", 64'(hs_fall[1] - hs_fall[0]), 64'd3200);
        chk("a_hs_width", 64'(hs_rise - hs_fall[0]), 64'd384);
        chk("a_de_rise", 64'(de_rise), 64'd12);
        chk("a_de_width", 64'(de_fall - de_rise), 64'd2560);
    endtask

    task automatic run_b();
        #1 rst_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("b_rst_vsync", 64'(vs_b), 64'd0);
        chk("b_rst_hsync", 64'(hs_b), 64'd0);
        #2 rst_b = 1'b0;
        goto_b(1);
        chk("b_fs_first", 64'(fs_b), 64'd1);
        chk("b_rv_first", 64'(rv_b), 64'd1);
        goto_b(171);
        chk("b_vs_line6", 64'(vs_b), 64'd0);
        goto_b(172);
        chk("b_vs_line7", 64'(vs_b), 64'd1);
        goto_b(219);
        chk("b_vs_line8", 64'(vs_b), 64'd1);
        goto_b(220);
        chk("b_vs_line9", 64'(vs_b), 64'd0);
        goto_b(264);
        chk("b_rv_last", 64'(rv_b), 64'd0);
        goto_b(265);
        chk("b_fs_wrap", 64'(fs_b), 64'd1);
        chk("b_oy_wrap", 64'(oy_b), 64'd0);
        chk("b_rv_wrap", 64'(rv_b), 64'd1);
        goto_b(656);
        chk("b_xy_pre", 64'({ox_b, oy_b}), 64'h32);
        chk("b_rgb_pre", 64'({r_b, g_b, b_b}), 64'h0202A5);
        chk("b_fs_count", 64'(fs_cnt_b), 64'd3);
        chk("b_fs_period", 64'(fs_last_b - fs_prev_b), 64'd264);
        #2 rst_b = 1'b1;
        #1;
        chk("b_mid_xy", 64'({ox_b, oy_b}), 64'd0);
        chk("b_mid_rv", 64'(rv_b), 64'd0);
        chk("b_mid_de", 64'(de_b), 64'd0);
        chk("b_mid_rgb", 64'({r_b, g_b, b_b}), 64'd0);
        chk("b_mid_sync", 64'({hs_b, vs_b}), 64'd0);
        repeat (3) @(negedge clk);
        #2 rst_b = 1'b0;
        goto_b(1);
        chk("b_fs_restart", 64'(fs_b), 64'd1);
        chk("b_xy_restart", 64'({ox_b, oy_b}), 64'd0);
        chk("b_de_restart", 64'(de_b), 64'd0);
        chk("b_rgb_restart", 64'({r_b, g_b, b_b}), 64'd0);
        goto_b(600);
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog n_a=%0d n_b=%0d", n_a, n_b);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
